mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM/WB pipeline register that sits directly downstream of the load/store unit.
//  - Captures the raw load word, ALU result and PC+4 for each instruction, along with its rd control.
//  - Extracts and sign/zero-extends the load byte or halfword.
//  - Selects the write-back value and presents it, registered, to the regfile and the forwarding unit.
//  - Supports stall (hold) and flush (bubble).
// PARAMETERS
//  XLEN      32  datapath width
//  RST_PC    0   reset value of o_pc
// PORTS
//  i_clk          in   1     clock, all state on rising edge
//  i_reset        in   1     asynchronous, active-low reset
//  i_valid        in   1     MEM stage holds a real instruction
//  i_stall        in   1     hold all registers this cycle
//  i_flush        in   1     load a bubble this cycle
//  i_pc           in   XLEN  PC of MEM instruction
//  i_rd_addr      in   5     destination register
//  i_rd_wren      in   1     instruction writes rd
//  i_wb_sel       in   2     0=ALU, 1=LOAD, 2=PC+4, 3=reserved (drives 0)
//  i_alu_data     in   XLEN  ALU result / LSU address
//  i_ld_raw       in   XLEN  LSU o_ld_data, word at aligned address
//  i_func3        in   3     load width/sign code
//  i_addr_lo      in   2     address bits [1:0]
//  o_valid        out  1     WB holds a real instruction
//  o_pc           out  XLEN  PC of WB instruction
//  o_rd_addr      out  5     regfile write address
//  o_rd_wren      out  1     regfile write enable
//  o_wb_data      out  XLEN  regfile write data / forward data
//  o_ld_misalign  out  1     WB load was misaligned (half@3, word@!0)
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - o_valid=0, o_rd_wren=0, o_rd_addr=0, o_wb_data=0, o_ld_misalign=0, o_pc=RST_PC.
//  - Latency: 1 cycle. Inputs sampled at edge N appear on outputs after edge N.
//  - Priority per edge: reset > flush > stall > capture.
//    - Flush: o_valid=0 and o_rd_wren=0. Other outputs are don't-care but are cleared to 0.
//    - Stall without flush: every output holds.
//    - Capture: register every field.
//  - Write-enable gating: o_rd_wren = i_valid & i_rd_wren & (i_rd_addr!=0).
//    - Writes to x0 never reach the regfile.
//  - Load format (combinational, ahead of the register), by func3:
//    - LB (000) / LBU (100): byte = raw[8*addr_lo +: 8], sign-extended / zero-extended.
//    - LH (001) / LHU (101): half = raw[16*addr_lo[1] +: 16], sign-extended / zero-extended.
//      addr_lo[0] is ignored; addr_lo=3 sets o_ld_misalign.
//    - LW (010): raw passes through; addr_lo!=0 sets o_ld_misalign.
//    - Any other func3: data=0, misalign=0.
//  - o_ld_misalign is valid only when i_wb_sel=LOAD; otherwise it is 0.
//  - WB select: ALU -> i_alu_data; LOAD -> formatted data; PC+4 -> i_pc+4 (modulo 2^XLEN); 3 -> 0.
//  - Simultaneous stall and flush: flush wins.
//  - Reset asserted mid-stall: state clears immediately, without waiting for a clock edge.
// CONFIGURATION
//  - Macro RETIRE_CNT_EN adds output o_retire_cnt [63:0].
//    - Reset value 0.
//    - Increments on every capture edge where i_valid=1 (no stall, no flush).
//    - Wraps from 2^64-1 to 0.
//    - Stalled and flushed cycles never count.
//  - Without RETIRE_CNT_EN: the port and the counter are absent; all other behaviour is identical.
// STRUCTURE
//  - Package pipeline_pkg:
//    - wb_sel_e enum (WB_ALU, WB_LOAD, WB_PC4).
//    - func3 load constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU).
//    - XLEN default.
//  - Sub-module ld_format: combinational byte/half extract and extend.
//    - Inputs: raw, func3, addr_lo. Outputs: data, misalign.
//  - Top: mem_wb_stage holds the pipeline register, WB mux, write-enable gating and optional counter.
// TESTING
//  1 Reset: drive i_reset=0 mid-stream -> all outputs at reset values without waiting for a clock edge;
//    o_rd_wren=0.
//  2 LB, raw=0x80FF_7F01, addr_lo=3 -> o_wb_data=0xFFFF_FF80.
//    Same with LBU -> 0x0000_0080.
//    Same with LHU, addr_lo=2 -> 0x0000_80FF.
//  3 LW, addr_lo=1 -> o_ld_misalign=1 and o_wb_data=raw.
//    LH, addr_lo=3 -> o_ld_misalign=1.
//  4 Capture rd=5, ALU=0x1234, then stall 3 cycles -> outputs hold.
//    Stall+flush together -> o_valid=0, o_rd_wren=0 on the next edge.
//  5 rd=0 with i_rd_wren=1 -> o_rd_wren=0.
//    WB_PC4 with i_pc=0xFFFF_FFFC -> o_wb_data=0.
//  6 RETIRE_CNT_EN: 10 valid captures, 2 stalls, 1 flush -> o_retire_cnt=10.
//    Force the counter to 2^64-1, then 1 capture -> o_retire_cnt=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: write-back select encoding, load func3 codes and default width.
package pipeline_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_LOAD = 2'd1,
      WB_PC4  = 2'd2
   } wb_sel_e;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/ld_format.sv
// Combinational load formatter: picks the byte/halfword out of the aligned load word
// and sign- or zero-extends it; flags misaligned halfword/word accesses.
module ld_format
   import pipeline_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic [XLEN-1:0] i_raw,
   input  logic [2:0]      i_func3,
   input  logic [1:0]      i_addr_lo,
   output logic [XLEN-1:0] o_data,
   output logic            o_misalign
);

   logic [XLEN-1:0] w_byte_sh;
   logic [XLEN-1:0] w_half_sh;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;

   // Halfword lane uses only addr_lo[1]; addr_lo[0] is deliberately ignored.
   assign w_byte_sh = i_raw >> {i_addr_lo, 3'b000};
   assign w_half_sh = i_raw >> {i_addr_lo[1], 4'b0000};
   assign w_byte    = w_byte_sh[7:0];
   assign w_half    = w_half_sh[15:0];

   always_comb begin
      o_data     = '0;
      o_misalign = 1'b0;
      case (i_func3)
         F3_LB:  o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
         F3_LBU: o_data = {{(XLEN-8){1'b0}}, w_byte};
         F3_LH: begin
            o_data     = {{(XLEN-16){w_half[15]}}, w_half};
            o_misalign = (i_addr_lo == 2'd3);
         end
         F3_LHU: begin
            o_data     = {{(XLEN-16){1'b0}}, w_half};
            o_misalign = (i_addr_lo == 2'd3);
         end
         F3_LW: begin
            o_data     = i_raw;
            o_misalign = (i_addr_lo != 2'd0);
         end
         default: begin
            o_data     = '0;
            o_misalign = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: load formatting, write-back select, rd write-enable gating,
// stall/flush handling. Optional retire counter enabled by macro RETIRE_CNT_EN.
module mem_wb_stage
   import pipeline_pkg::*;
#(
   parameter int              XLEN   = XLEN_DEFAULT,
   parameter logic [XLEN-1:0] RST_PC = '0
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic            i_valid,
   input  logic            i_stall,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_pc,
   input  logic [4:0]      i_rd_addr,
   input  logic            i_rd_wren,
   input  logic [1:0]      i_wb_sel,
   input  logic [XLEN-1:0] i_alu_data,
   input  logic [XLEN-1:0] i_ld_raw,
   input  logic [2:0]      i_func3,
   input  logic [1:0]      i_addr_lo,
   output logic            o_valid,
   output logic [XLEN-1:0] o_pc,
   output logic [4:0]      o_rd_addr,
   output logic            o_rd_wren,
   output logic [XLEN-1:0] o_wb_data,
   output logic            o_ld_misalign
`ifdef RETIRE_CNT_EN
   ,
   output logic [63:0]     o_retire_cnt
`endif
);

   logic [XLEN-1:0] w_ld_data;
   logic            w_ld_misalign;
   logic [XLEN-1:0] w_wb_data;
   logic            w_misalign;
   logic            w_rd_wren;
   logic            w_capture;

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [4:0]      r_rd_addr;
   logic            r_rd_wren;
   logic [XLEN-1:0] r_wb_data;
   logic            r_ld_misalign;

   ld_format #(.XLEN(XLEN)) u_ld_format (
      .i_raw      (i_ld_raw),
      .i_func3    (i_func3),
      .i_addr_lo  (i_addr_lo),
      .o_data     (w_ld_data),
      .o_misalign (w_ld_misalign)
   );

   always_comb begin
      w_wb_data = '0;
      case (i_wb_sel)
         WB_ALU:  w_wb_data = i_alu_data;
         WB_LOAD: w_wb_data = w_ld_data;
         WB_PC4:  w_wb_data = i_pc + XLEN'(4);
         default: w_wb_data = '0;
      endcase
   end

   // Misalign is only meaningful for loads; x0 writes never reach the regfile.
   assign w_misalign = (i_wb_sel == WB_LOAD) && w_ld_misalign;
   assign w_rd_wren  = i_valid && i_rd_wren && (i_rd_addr != 5'd0);
   assign w_capture  = !i_flush && !i_stall;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_valid       <= 1'b0;
         r_pc          <= RST_PC;
         r_rd_addr     <= '0;
         r_rd_wren     <= 1'b0;
         r_wb_data     <= '0;
         r_ld_misalign <= 1'b0;
      end else if (i_flush) begin
         r_valid       <= 1'b0;
         r_pc          <= '0;
         r_rd_addr     <= '0;
         r_rd_wren     <= 1'b0;
         r_wb_data     <= '0;
         r_ld_misalign <= 1'b0;
      end else if (!i_stall) begin
         r_valid       <= i_valid;
         r_pc          <= i_pc;
         r_rd_addr     <= i_rd_addr;
         r_rd_wren     <= w_rd_wren;
         r_wb_data     <= w_wb_data;
         r_ld_misalign <= w_misalign;
      end
   end

   assign o_valid       = r_valid;
   assign o_pc          = r_pc;
   assign o_rd_addr     = r_rd_addr;
   assign o_rd_wren     = r_rd_wren;
   assign o_wb_data     = r_wb_data;
   assign o_ld_misalign = r_ld_misalign;

`ifdef RETIRE_CNT_EN
   logic [63:0] r_retire_cnt;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_retire_cnt <= '0;
      end else if (w_capture && i_valid) begin
         r_retire_cnt <= r_retire_cnt + 64'd1;
      end
   end

   assign o_retire_cnt = r_retire_cnt;
`else
   logic w_unused;
   assign w_unused = w_capture;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage against a behavioural model; directed corner cases first.
module tb_mem_wb_stage;
   import pipeline_pkg::*;

   localparam int XLEN = 32;

   logic            i_clk = 1'b0;
   logic            i_reset;
   logic            i_valid, i_stall, i_flush, i_rd_wren;
   logic [XLEN-1:0] i_pc, i_alu_data, i_ld_raw;
   logic [4:0]      i_rd_addr;
   logic [1:0]      i_wb_sel, i_addr_lo;
   logic [2:0]      i_func3;
   logic            o_valid, o_rd_wren, o_ld_misalign;
   logic [XLEN-1:0] o_pc, o_wb_data;
   logic [4:0]      o_rd_addr;
`ifdef RETIRE_CNT_EN
   logic [63:0]     o_retire_cnt;
`endif

   int n_vec  = 0;
   int n_fail = 0;

   logic            m_valid, m_wren, m_mis;
   logic [XLEN-1:0] m_pc, m_data;
   logic [4:0]      m_rd;
   longint unsigned m_cnt;

   mem_wb_stage #(.XLEN(XLEN), .RST_PC(32'h0000_0000)) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_valid       (i_valid),
      .i_stall       (i_stall),
      .i_flush       (i_flush),
      .i_pc          (i_pc),
      .i_rd_addr     (i_rd_addr),
      .i_rd_wren     (i_rd_wren),
      .i_wb_sel      (i_wb_sel),
      .i_alu_data    (i_alu_data),
      .i_ld_raw      (i_ld_raw),
      .i_func3       (i_func3),
      .i_addr_lo     (i_addr_lo),
      .o_valid       (o_valid),
      .o_pc          (o_pc),
      .o_rd_addr     (o_rd_addr),
      .o_rd_wren     (o_rd_wren),
      .o_wb_data     (o_wb_data),
      .o_ld_misalign (o_ld_misalign)
`ifdef RETIRE_CNT_EN
      ,
      .o_retire_cnt  (o_retire_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference load formatting from the ISA rules, using plain integer arithmetic.
   function automatic logic [32:0] ref_load(input logic [31:0] raw, input int f3, input int lo);
      longint unsigned b, h, d;
      logic mis;
      b   = (raw >> (8 * lo)) & 32'hFF;
      h   = (raw >> (16 * (lo / 2))) & 32'hFFFF;
      d   = 0;
      mis = 1'b0;
      case (f3)
         0: d = (b >= 128) ? (b + 64'hFFFF_FF00) : b;
         4: d = b;
         1: begin d = (h >= 32768) ? (h + 64'hFFFF_0000) : h; mis = (lo == 3); end
         5: begin d = h; mis = (lo == 3); end
         2: begin d = raw; mis = (lo != 0); end
         default: begin d = 0; mis = 1'b0; end
      endcase
      return {mis, d[31:0]};
   endfunction

   task automatic model_reset();
      m_valid = 0; m_wren = 0; m_mis = 0; m_pc = 32'h0; m_data = 0; m_rd = 0; m_cnt = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, ".valid"}, 64'(o_valid), 64'(m_valid));
      check({tag, ".pc"}, 64'(o_pc), 64'(m_pc));
      check({tag, ".rd"}, 64'(o_rd_addr), 64'(m_rd));
      check({tag, ".wren"}, 64'(o_rd_wren), 64'(m_wren));
      check({tag, ".data"}, 64'(o_wb_data), 64'(m_data));
      check({tag, ".mis"}, 64'(o_ld_misalign), 64'(m_mis));
`ifdef RETIRE_CNT_EN
      check({tag, ".cnt"}, o_retire_cnt, m_cnt);
`endif
   endtask

   // Apply one set of inputs across a rising edge, advance the model, check #1 after.
   task automatic cyc(input string tag, input logic v, input logic st, input logic fl,
                      input logic [31:0] pc, input logic [4:0] rd, input logic we,
                      input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] raw,
                      input logic [2:0] f3, input logic [1:0] lo);
      logic [32:0] ld;
      i_valid = v; i_stall = st; i_flush = fl; i_pc = pc; i_rd_addr = rd; i_rd_wren = we;
      i_wb_sel = sel; i_alu_data = alu; i_ld_raw = raw; i_func3 = f3; i_addr_lo = lo;
      ld = ref_load(raw, int'(f3), int'(lo));
      if (fl) begin
         m_valid = 0; m_wren = 0; m_mis = 0; m_pc = 0; m_data = 0; m_rd = 0;
      end else if (!st) begin
         m_valid = v;
         m_pc    = pc;
         m_rd    = rd;
         m_wren  = v && we && (rd != 0);
         case (sel)
            2'd0: m_data = alu;
            2'd1: m_data = ld[31:0];
            2'd2: m_data = 32'((64'(pc) + 4) % 64'h1_0000_0000);
            default: m_data = 0;
         endcase
         m_mis = (sel == 2'd1) ? ld[32] : 1'b0;
         if (v) m_cnt = m_cnt + 1;
      end
      @(posedge i_clk);
      #1;
      check_all(tag);
   endtask

   task automatic cyc_rand();
      cyc("rnd", 1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
          $urandom, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
          2'($urandom), $urandom, $urandom, 3'($urandom), 2'($urandom));
   endtask

   initial begin
      i_reset = 0; i_valid = 0; i_stall = 0; i_flush = 0; i_pc = 0; i_rd_addr = 0;
      i_rd_wren = 0; i_wb_sel = 0; i_alu_data = 0; i_ld_raw = 0; i_func3 = 0; i_addr_lo = 0;
      model_reset();
      #12;
      check_all("rst");
      i_reset = 1;
      @(posedge i_clk); #1;

      // Byte/halfword extraction corners
      cyc("lb3", 1, 0, 0, 32'h100, 5'd1, 1, 2'd1, 0, 32'h80FF_7F01, F3_LB, 2'd3);
      check("lb3.k", 64'(o_wb_data), 64'hFFFF_FF80);
      cyc("lbu3", 1, 0, 0, 32'h104, 5'd1, 1, 2'd1, 0, 32'h80FF_7F01, F3_LBU, 2'd3);
      check("lbu3.k", 64'(o_wb_data), 64'h0000_0080);
      cyc("lhu2", 1, 0, 0, 32'h108, 5'd1, 1, 2'd1, 0, 32'h80FF_7F01, F3_LHU, 2'd2);
      check("lhu2.k", 64'(o_wb_data), 64'h0000_80FF);
      cyc("lw1", 1, 0, 0, 32'h10C, 5'd2, 1, 2'd1, 0, 32'hDEAD_BEEF, F3_LW, 2'd1);
      check("lw1.mis", 64'(o_ld_misalign), 64'd1);
      check("lw1.k", 64'(o_wb_data), 64'hDEAD_BEEF);
      cyc("lh3", 1, 0, 0, 32'h110, 5'd2, 1, 2'd1, 0, 32'h1234_5678, F3_LH, 2'd3);
      check("lh3.mis", 64'(o_ld_misalign), 64'd1);
      cyc("lwalu", 1, 0, 0, 32'h114, 5'd2, 1, 2'd0, 32'h55, 32'h1, F3_LW, 2'd1);
      check("lwalu.mis", 64'(o_ld_misalign), 64'd0);

      // Capture then hold across a 3-cycle stall, then stall+flush
      cyc("cap", 1, 0, 0, 32'h200, 5'd5, 1, 2'd0, 32'h1234, 0, F3_LW, 2'd0);
      check("cap.rd", 64'(o_rd_addr), 64'd5);
      check("cap.k", 64'(o_wb_data), 64'h1234);
      for (int i = 0; i < 3; i++)
         cyc("stall", 1, 1, 0, $urandom, 5'd9, 1, 2'd0, $urandom, 0, F3_LW, 2'd0);
      check("stall.k", 64'(o_wb_data), 64'h1234);
      cyc("stfl", 1, 1, 1, 32'h300, 5'd7, 1, 2'd0, 32'h77, 0, F3_LW, 2'd0);
      check("stfl.valid", 64'(o_valid), 64'd0);
      check("stfl.wren", 64'(o_rd_wren), 64'd0);

      // x0 gating and PC+4 wrap
      cyc("x0", 1, 0, 0, 32'h400, 5'd0, 1, 2'd0, 32'h99, 0, F3_LW, 2'd0);
      check("x0.wren", 64'(o_rd_wren), 64'd0);
      cyc("pc4", 1, 0, 0, 32'hFFFF_FFFC, 5'd3, 1, 2'd2, 0, 0, F3_LW, 2'd0);
      check("pc4.k", 64'(o_wb_data), 64'd0);
      cyc("rsv", 1, 0, 0, 32'h500, 5'd3, 1, 2'd3, 32'hABCD, 32'hFFFF, F3_LW, 2'd0);

      for (int i = 0; i < 200; i++) cyc_rand();

      // Asynchronous reset mid-stall, observed before any edge
      cyc("pre", 1, 0, 0, 32'h600, 5'd4, 1, 2'd0, 32'hCAFE, 0, F3_LW, 2'd0);
      i_stall = 1;
      #2;
      i_reset = 0;
      #1;
      model_reset();
      check("arst.valid", 64'(o_valid), 64'd0);
      check("arst.wren", 64'(o_rd_wren), 64'd0);
      check("arst.rd", 64'(o_rd_addr), 64'd0);
      check("arst.data", 64'(o_wb_data), 64'd0);
      check("arst.mis", 64'(o_ld_misalign), 64'd0);
      check("arst.pc", 64'(o_pc), 64'd0);
      @(negedge i_clk);
      i_reset = 1;
      i_stall = 0;

`ifdef RETIRE_CNT_EN
      for (int i = 0; i < 10; i++)
         cyc("rc", 1, 0, 0, $urandom, 5'd1, 1, 2'd0, $urandom, 0, F3_LW, 2'd0);
      cyc("rcst", 1, 1, 0, 0, 5'd1, 1, 2'd0, 0, 0, F3_LW, 2'd0);
      cyc("rcst", 1, 1, 0, 0, 5'd1, 1, 2'd0, 0, 0, F3_LW, 2'd0);
      cyc("rcfl", 1, 0, 1, 0, 5'd1, 1, 2'd0, 0, 0, F3_LW, 2'd0);
      check("rc10", o_retire_cnt, 64'd10);
      @(negedge i_clk);
      dut.r_retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      cyc("rcwrap", 1, 0, 0, 0, 5'd1, 1, 2'd0, 0, 0, F3_LW, 2'd0);
      check("rcwrap.k", o_retire_cnt, 64'd0);
`endif

      for (int i = 0; i < 200; i++) cyc_rand();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
